// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
// Initiator side of the ALU controller handshake. Decoded ops from the issue
// stage are buffered in a small FIFO and presented to the controller one at a
// time: a one-cycle select pulse (plus a copy delayed by one cycle), operands
// held stable until the controller reports writeback, then a retire pulse
// carrying the wavefront ID. A saturating watchdog flags a controller that
// never completes.
module alu_issue_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PTR_W          = 2,
    parameter int WFID_W         = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue_valid,
    output logic              o_issue_ready,
    input  logic [WFID_W-1:0] i_issue_wfid,
    input  logic [31:0]       i_issue_opcode,
    input  logic [11:0]       i_issue_src1_addr,
    input  logic [11:0]       i_issue_src2_addr,
    input  logic [11:0]       i_issue_src3_addr,
    input  logic [11:0]       i_issue_dest1_addr,
    input  logic [11:0]       i_issue_dest2_addr,
    input  logic              i_alu_ready,
    input  logic              i_instr_done,
    output logic              o_alu_select,
    output logic              o_alu_select_flopped,
    output logic [11:0]       o_src1_addr,
    output logic [11:0]       o_src2_addr,
    output logic [11:0]       o_src3_addr,
    output logic [11:0]       o_dest1_addr,
    output logic [11:0]       o_dest2_addr,
    output logic [31:0]       o_opcode,
    output logic              o_retire_valid,
    output logic [WFID_W-1:0] o_retire_wfid,
    output logic              o_busy,
    output logic              o_timeout_err
);

    // Entry layout, MSB to LSB: wfid, opcode, src1, src2, src3, dest1, dest2
    localparam int ENTRY_W  = WFID_W + 32 + 5 * 12;
    localparam int OFS_DST1 = 12;
    localparam int OFS_SRC3 = 24;
    localparam int OFS_SRC2 = 36;
    localparam int OFS_SRC1 = 48;
    localparam int OFS_OPC  = 60;
    localparam int OFS_WFID = 92;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]     TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SELECT    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ENTRY_W-1:0]  r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;

    logic [ENTRY_W-1:0]  r_hold_entry;
    logic                r_alu_select;
    logic                r_alu_select_flopped;
    logic                r_retire_valid;
    logic [WFID_W-1:0]   r_retire_wfid;
    logic [7:0]          r_watchdog;
    logic                r_timeout_err;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [ENTRY_W-1:0]  w_push_entry;
    logic [ENTRY_W-1:0]  w_head_entry;
    logic                w_select_next;
    logic                w_flopped_next;
    logic                w_retire_next;
    logic [7:0]          w_watchdog_next;
    logic                w_timeout_next;

    // Full is taken from the registered count only, so a pop in the same
    // cycle never opens a slot for a push.
    assign w_full       = (r_count == FULL_COUNT);
    assign w_empty      = (r_count == '0);
    assign w_push       = i_issue_valid && !w_full;
    assign w_push_entry = {i_issue_wfid, i_issue_opcode, i_issue_src1_addr,
                           i_issue_src2_addr, i_issue_src3_addr,
                           i_issue_dest1_addr, i_issue_dest2_addr};
    assign w_head_entry = r_fifo_mem[r_rd_ptr];

    // Per-entry write enables for the op buffer storage
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            // Capture the offered op into the slot the write pointer names
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_fifo_mem[gi] <= w_push_entry;
                end
            end
        end
    endgenerate

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, pop decision and next values of the registered outputs
    always_comb begin
        w_state_next    = r_state;
        w_pop           = 1'b0;
        w_select_next   = 1'b0;
        w_flopped_next  = 1'b0;
        w_retire_next   = 1'b0;
        w_watchdog_next = r_watchdog;
        w_timeout_next  = r_timeout_err;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && i_alu_ready) begin
                    w_pop         = 1'b1;
                    w_select_next = 1'b1;
                    w_state_next  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                w_flopped_next = 1'b1;
                w_state_next   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_instr_done) begin
                    w_retire_next   = 1'b1;
                    w_watchdog_next = '0;
                    w_state_next    = ST_IDLE;
                end else begin
                    if (r_watchdog != 8'hFF) begin
                        w_watchdog_next = r_watchdog + 8'd1;
                    end
                    if (w_watchdog_next == TIMEOUT_VAL) begin
                        w_timeout_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output, hold and watchdog registers; hold regs load only at the pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_entry         <= '0;
            r_alu_select         <= 1'b0;
            r_alu_select_flopped <= 1'b0;
            r_retire_valid       <= 1'b0;
            r_retire_wfid        <= '0;
            r_watchdog           <= '0;
            r_timeout_err        <= 1'b0;
        end else begin
            if (w_pop) begin
                r_hold_entry <= w_head_entry;
            end
            r_alu_select         <= w_select_next;
            r_alu_select_flopped <= w_flopped_next;
            r_retire_valid       <= w_retire_next;
            if (w_retire_next) begin
                r_retire_wfid <= r_hold_entry[OFS_WFID +: WFID_W];
            end
            r_watchdog    <= w_watchdog_next;
            r_timeout_err <= w_timeout_next;
        end
    end

    assign o_issue_ready        = !w_full;
    assign o_alu_select         = r_alu_select;
    assign o_alu_select_flopped = r_alu_select_flopped;
    assign o_src1_addr          = r_hold_entry[OFS_SRC1 +: 12];
    assign o_src2_addr          = r_hold_entry[OFS_SRC2 +: 12];
    assign o_src3_addr          = r_hold_entry[OFS_SRC3 +: 12];
    assign o_dest1_addr         = r_hold_entry[OFS_DST1 +: 12];
    assign o_dest2_addr         = r_hold_entry[0 +: 12];
    assign o_opcode             = r_hold_entry[OFS_OPC +: 32];
    assign o_retire_valid       = r_retire_valid;
    assign o_retire_wfid        = r_retire_wfid;
    assign o_busy               = (r_state != ST_IDLE) || !w_empty;
    assign o_timeout_err        = r_timeout_err;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer. A transaction-level model
// (queue of accepted ops, the op currently owned by the controller, and a
// count of unanswered wait cycles) predicts every output each cycle.
module tb_alu_issue_sequencer;

    typedef struct {
        logic [5:0]  wfid;
        logic [31:0] opcode;
        logic [11:0] s1, s2, s3, d1, d2;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [5:0]  issue_wfid = '0;
    logic [31:0] issue_opcode = '0;
    logic [11:0] issue_src1 = '0, issue_src2 = '0, issue_src3 = '0;
    logic [11:0] issue_dest1 = '0, issue_dest2 = '0;
    logic        alu_ready = 1'b0;
    logic        instr_done = 1'b0;
    logic        alu_select, alu_select_flopped;
    logic [11:0] src1, src2, src3, dest1, dest2;
    logic [31:0] opcode;
    logic        retire_valid;
    logic [5:0]  retire_wfid;
    logic        busy, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_retire_seen = 0;

    // Reference model state
    op_t q[$];
    op_t m_cur;
    bit  m_inflight = 0;     // controller owns m_cur (select issued, not yet retired)
    bit  m_sel_pulse = 0;    // select pulse is high this cycle
    int  m_wait_cnt = 0;     // cycles waited for done without an answer
    bit  m_err = 0;
    logic [5:0] m_ret_wfid = '0;
    int  m_pushed = 0;
    int  m_retired = 0;

    alu_issue_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_issue_valid        (issue_valid),
        .o_issue_ready        (issue_ready),
        .i_issue_wfid         (issue_wfid),
        .i_issue_opcode       (issue_opcode),
        .i_issue_src1_addr    (issue_src1),
        .i_issue_src2_addr    (issue_src2),
        .i_issue_src3_addr    (issue_src3),
        .i_issue_dest1_addr   (issue_dest1),
        .i_issue_dest2_addr   (issue_dest2),
        .i_alu_ready          (alu_ready),
        .i_instr_done         (instr_done),
        .o_alu_select         (alu_select),
        .o_alu_select_flopped (alu_select_flopped),
        .o_src1_addr          (src1),
        .o_src2_addr          (src2),
        .o_src3_addr          (src3),
        .o_dest1_addr         (dest1),
        .o_dest2_addr         (dest2),
        .o_opcode             (opcode),
        .o_retire_valid       (retire_valid),
        .o_retire_wfid        (retire_wfid),
        .o_busy               (busy),
        .o_timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_waiting();
        return m_inflight && !m_sel_pulse;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cur = '{default: '0};
        m_inflight = 0;
        m_sel_pulse = 0;
        m_wait_cnt = 0;
        m_err = 0;
        m_ret_wfid = '0;
    endtask

    task automatic compare_all(input bit e_sel, input bit e_flop, input bit e_ret);
        check("alu_select", alu_select, e_sel);
        check("alu_select_flopped", alu_select_flopped, e_flop);
        check("retire_valid", retire_valid, e_ret);
        check("retire_wfid", retire_wfid, m_ret_wfid);
        check("opcode", opcode, m_cur.opcode);
        check("src1", src1, m_cur.s1);
        check("src2", src2, m_cur.s2);
        check("src3", src3, m_cur.s3);
        check("dest1", dest1, m_cur.d1);
        check("dest2", dest2, m_cur.d2);
        check("issue_ready", issue_ready, (q.size() < 4));
        check("busy", busy, (m_inflight || q.size() > 0));
        check("timeout_err", timeout_err, m_err);
    endtask

    // One clock: predict from current inputs, advance, sample 1 time unit after the edge
    task automatic step();
        bit push, e_sel, e_flop, e_ret;
        op_t in_op;
        in_op.wfid = issue_wfid;   in_op.opcode = issue_opcode;
        in_op.s1 = issue_src1;     in_op.s2 = issue_src2;  in_op.s3 = issue_src3;
        in_op.d1 = issue_dest1;    in_op.d2 = issue_dest2;
        push = issue_valid && issue_ready;
        e_sel = 0; e_flop = 0; e_ret = 0;
        if (rst) begin
            model_reset();
        end else begin
            e_sel  = !m_inflight && (q.size() > 0) && alu_ready;
            e_flop = m_sel_pulse;
            e_ret  = m_waiting() && instr_done;
            if (m_waiting()) begin
                if (instr_done) m_wait_cnt = 0;
                else begin
                    if (m_wait_cnt < 255) m_wait_cnt++;
                    if (m_wait_cnt == 255) m_err = 1;
                end
            end
            if (e_ret) begin
                m_inflight = 0;
                m_ret_wfid = m_cur.wfid;
                m_retired++;
            end
            m_sel_pulse = e_sel;
            if (e_sel) begin
                m_cur = q.pop_front();
                m_inflight = 1;
            end
            if (push) begin
                q.push_back(in_op);
                m_pushed++;
            end
        end
        @(posedge clk);
        #1;
        if (retire_valid === 1'b1) n_retire_seen++;
        compare_all(e_sel, e_flop, e_ret);
    endtask

    task automatic set_op(input logic [5:0] w, input logic [31:0] opc, input logic [11:0] s1);
        issue_wfid = w;  issue_opcode = opc;  issue_src1 = s1;
        issue_src2 = 12'($urandom);  issue_src3 = 12'($urandom);
        issue_dest1 = 12'($urandom); issue_dest2 = 12'($urandom);
    endtask

    // Offer the current op until accepted; pulse done on attempt done_at (-1 = never)
    task automatic push_op(input int done_at);
        bit acc = 0;
        issue_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            acc = issue_ready;
            instr_done = (k == done_at);
            step();
            if (acc) break;
        end
        issue_valid = 1'b0;
        instr_done = 1'b0;
        check("push_accepted", acc, 1'b1);
    endtask

    task automatic drain();
        bit empty = 0;
        alu_ready = 1'b1;
        for (int k = 0; k < 500; k++) begin
            if (!m_inflight && q.size() == 0) begin
                empty = 1;
                break;
            end
            instr_done = m_waiting();
            step();
        end
        instr_done = 1'b0;
        check("drain_done", empty, 1'b1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(0, 0, 0);
        instr_done = 1'b1;
        step();
        step();
        rst = 1'b0;
        instr_done = 1'b0;
    endtask

    initial begin
        int base, dly, steps;
        model_reset();
        // Reset state
        async_reset();
        step();

        // T1: single op, done 4 cycles after select
        alu_ready = 1'b1;
        base = n_retire_seen;
        set_op(6'd5, 32'h0000_0103, 12'h800);
        push_op(-1);
        step();
        check("t1_select", alu_select, 1'b1);
        step();
        check("t1_flopped", alu_select_flopped, 1'b1);
        step(); step();
        instr_done = 1'b1;
        step();
        instr_done = 1'b0;
        check("t1_retire_wfid", retire_wfid, 6'd5);
        step(); step();
        check("t1_retire_once", n_retire_seen - base, 1);

        // T2: six ops back-to-back with no done until the FIFO fills
        for (int i = 0; i < 6; i++) begin
            set_op(6'(i), $urandom, 12'($urandom));
            push_op(8);
        end
        drain();

        // T3: alu_ready low with FIFO non-empty
        alu_ready = 1'b0;
        set_op(6'd9, 32'hCAFE_0009, 12'h123);
        push_op(-1);
        repeat (10) step();
        alu_ready = 1'b1;
        step();
        check("t3_select", alu_select, 1'b1);
        check("t3_src1", src1, 12'h123);
        drain();

        // T4: watchdog, late done still retires, flag sticky
        set_op(6'd17, 32'h0000_0017, 12'h017);
        push_op(-1);
        repeat (300) step();
        check("t4_timeout", timeout_err, 1'b1);
        drain();
        set_op(6'd18, 32'h0000_0018, 12'h018);
        push_op(-1);
        drain();
        check("t4_sticky", timeout_err, 1'b1);

        // T5: reset while waiting with three buffered ops, then spurious done
        alu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(6'(20 + i), $urandom, 12'($urandom));
            push_op(-1);
        end
        repeat (3) step();
        base = n_retire_seen;
        async_reset();
        instr_done = 1'b1;
        step();
        instr_done = 1'b0;
        step();
        check("t5_no_retire", n_retire_seen - base, 0);

        // T6: random traffic
        m_pushed = 0;
        m_retired = 0;
        base = n_retire_seen;
        dly = 0;
        steps = 0;
        while (m_pushed < 1000 && steps < 60000) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            set_op(6'($urandom), $urandom, 12'($urandom));
            alu_ready = ($urandom_range(0, 3) != 0);
            if (m_sel_pulse) dly = $urandom_range(1, 20);
            if (m_waiting()) begin
                dly--;
                instr_done = (dly <= 0);
            end else begin
                instr_done = ($urandom_range(0, 9) == 0);
            end
            step();
            steps++;
        end
        issue_valid = 1'b0;
        check("t6_all_pushed", m_pushed, 1000);
        drain();
        check("t6_retire_count", n_retire_seen - base, m_retired);
        check("t6_retired_all", m_retired, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
